// File: rtl/sd_xfer_sequencer_pkg.sv
// rtl/sd_xfer_sequencer_pkg.sv - shared states, IRQ bit map and CMD12 constant (SD_XFER_AUTO_CMD12_EN adds abort states)
package sd_xfer_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ISSUE       = 3'd1,
        WAIT_RESP   = 3'd2,
        DATA        = 3'd3
`ifdef SD_XFER_AUTO_CMD12_EN
        ,
        ABORT_ISSUE = 3'd4,
        ABORT_WAIT  = 3'd5
`endif
    } state_t;

    localparam int IRQ_CMD_DONE  = 0;
    localparam int IRQ_XFER_DONE = 1;
    localparam int IRQ_CMD_TO    = 2;
    localparam int IRQ_DAT_ERR   = 3;

    localparam logic [5:0] CMD12_INDEX = 6'd12;

endpackage

// File: rtl/sd_cmd_queue.sv
// rtl/sd_cmd_queue.sv - descriptor FIFO with full/empty flags; pushes while full are dropped
module sd_cmd_queue #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sd_xfer_sequencer.sv
// rtl/sd_xfer_sequencer.sv - queues command writes, issues CMD/DAT, tracks blocks and sticky IRQs (optional SD_XFER_AUTO_CMD12_EN)
module sd_xfer_sequencer
    import sd_xfer_sequencer_pkg::*;
#(
    parameter int              CMD_Q_DEPTH = 2,
    parameter int              BLK_CNT_W   = 16,
    parameter int              TO_W        = 20,
    parameter logic [TO_W-1:0] TO_LIMIT    = 20'hFFFFF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 cmd_wr,
    input  logic [5:0]           cmd_index_in,
    input  logic [31:0]          cmd_arg_in,
    input  logic                 data_present_in,
    input  logic [BLK_CNT_W-1:0] blk_cnt_in,
    input  logic                 multi_blk_in,
    input  logic                 cmd_complete,
    input  logic                 cmd_timeout,
    input  logic                 blk_done,
    input  logic                 dat_error,
    input  logic [3:0]           irq_clr,
    output logic                 new_cmd,
    output logic [5:0]           cmd_index_out,
    output logic [31:0]          cmd_arg_out,
    output logic                 start_transfer,
    output logic                 cmd_inhibit,
    output logic                 dat_inhibit,
    output logic                 q_full,
    output logic [BLK_CNT_W-1:0] blk_remaining,
    output logic [3:0]           irq_status
);

    localparam int QW = 6 + 32 + 1 + BLK_CNT_W + 1;

    state_t               state, next_state;
    logic [QW-1:0]        q_wdata, q_rdata;
    logic                 q_empty;
    logic [5:0]           head_index;
    logic [31:0]          head_arg;
    logic                 head_dp, head_multi;
    logic [BLK_CNT_W-1:0] head_blk;
    logic [5:0]           hold_index;
    logic [31:0]          hold_arg;
    logic                 hold_dp, hold_multi;
    logic [BLK_CNT_W-1:0] hold_blk, blk_rem;
    logic [TO_W-1:0]      to_cnt;
    logic [3:0]           irq_q, irq_set;
    logic                 start_q, load_head, start_set, blk_dec, to_clr;
`ifdef SD_XFER_AUTO_CMD12_EN
    logic                 load_cmd12, abort_err, abort_err_d;
`endif

    assign q_wdata = {cmd_index_in, cmd_arg_in, data_present_in, blk_cnt_in, multi_blk_in};
    assign {head_index, head_arg, head_dp, head_blk, head_multi} = q_rdata;

    sd_cmd_queue #(.WIDTH(QW), .DEPTH(CMD_Q_DEPTH)) u_cmd_queue (
        .clk   (CLK),
        .rst   (RESET),
        .push  (cmd_wr),
        .pop   (load_head),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_head  = 1'b0;
        start_set  = 1'b0;
        blk_dec    = 1'b0;
        to_clr     = 1'b0;
        irq_set    = '0;
`ifdef SD_XFER_AUTO_CMD12_EN
        load_cmd12  = 1'b0;
        abort_err_d = 1'b0;
`endif
        // a write into a full queue is reported through the cmd_to bit
        irq_set[IRQ_CMD_TO] = cmd_wr && q_full;
        unique case (state)
            IDLE: begin
                if (!q_empty) begin
                    load_head  = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT_RESP;
            WAIT_RESP: begin
                if (cmd_timeout) begin
                    irq_set[IRQ_CMD_TO] = 1'b1;
                    next_state          = IDLE;
                end else if (cmd_complete) begin
                    irq_set[IRQ_CMD_DONE] = 1'b1;
                    if (hold_dp && (hold_blk != '0)) begin
                        start_set  = 1'b1;
                        to_clr     = 1'b1;
                        next_state = DATA;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                blk_dec = blk_done && (blk_rem != '0);
                to_clr  = blk_done;
                if (dat_error || (to_cnt == TO_LIMIT)) begin
                    irq_set[IRQ_DAT_ERR] = 1'b1;
`ifdef SD_XFER_AUTO_CMD12_EN
                    load_cmd12  = 1'b1;
                    abort_err_d = 1'b1;
                    next_state  = ABORT_ISSUE;
`else
                    next_state = IDLE;
`endif
                end else if (blk_dec && (blk_rem == BLK_CNT_W'(1))) begin
`ifdef SD_XFER_AUTO_CMD12_EN
                    if (hold_multi) begin
                        load_cmd12 = 1'b1;
                        next_state = ABORT_ISSUE;
                    end else begin
                        irq_set[IRQ_XFER_DONE] = 1'b1;
                        next_state             = IDLE;
                    end
`else
                    irq_set[IRQ_XFER_DONE] = 1'b1;
                    next_state             = IDLE;
`endif
                end
            end
`ifdef SD_XFER_AUTO_CMD12_EN
            ABORT_ISSUE: next_state = ABORT_WAIT;
            ABORT_WAIT: begin
                if (cmd_timeout) begin
                    irq_set[IRQ_CMD_TO] = 1'b1;
                    next_state          = IDLE;
                end else if (cmd_complete) begin
                    irq_set[IRQ_XFER_DONE] = !abort_err;
                    next_state             = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_index <= '0;
            hold_arg   <= '0;
            hold_dp    <= 1'b0;
            hold_blk   <= '0;
            hold_multi <= 1'b0;
            blk_rem    <= '0;
            to_cnt     <= '0;
            irq_q      <= '0;
            start_q    <= 1'b0;
`ifdef SD_XFER_AUTO_CMD12_EN
            abort_err  <= 1'b0;
`endif
        end else begin
            start_q <= start_set;
            irq_q   <= (irq_q & ~irq_clr) | irq_set;
            if (load_head) begin
                hold_index <= head_index;
                hold_arg   <= head_arg;
                hold_dp    <= head_dp;
                hold_blk   <= head_blk;
                hold_multi <= head_multi;
            end
`ifdef SD_XFER_AUTO_CMD12_EN
            else if (load_cmd12) begin
                hold_index <= CMD12_INDEX;
                hold_arg   <= '0;
                abort_err  <= abort_err_d;
            end
`endif
            if (start_set)    blk_rem <= hold_multi ? hold_blk : BLK_CNT_W'(1);
            else if (blk_dec) blk_rem <= blk_rem - BLK_CNT_W'(1);
            if (to_clr)             to_cnt <= '0;
            else if (state == DATA) to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign cmd_index_out  = hold_index;
    assign cmd_arg_out    = hold_arg;
    assign start_transfer = start_q;
    assign blk_remaining  = blk_rem;
    assign irq_status     = irq_q;
`ifdef SD_XFER_AUTO_CMD12_EN
    assign new_cmd     = (state == ISSUE) || (state == ABORT_ISSUE);
    assign cmd_inhibit = (state == ISSUE) || (state == WAIT_RESP) ||
                         (state == ABORT_ISSUE) || (state == ABORT_WAIT);
    assign dat_inhibit = (state == DATA) || (state == ABORT_ISSUE) || (state == ABORT_WAIT);
`else
    assign new_cmd     = (state == ISSUE);
    assign cmd_inhibit = (state == ISSUE) || (state == WAIT_RESP);
    assign dat_inhibit = (state == DATA);
`endif

endmodule

// File: tb/tb_sd_xfer_sequencer.sv
// tb/tb_sd_xfer_sequencer.sv - directed self-checking bench for sd_xfer_sequencer (default build, TO_LIMIT 16)
`define CHECK(tag, obs, exp) \
    begin \
        n_tests++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
        end \
    end

module tb_sd_xfer_sequencer;

    logic        CLK, RESET;
    logic        cmd_wr, data_present_in, multi_blk_in;
    logic [5:0]  cmd_index_in;
    logic [31:0] cmd_arg_in;
    logic [15:0] blk_cnt_in;
    logic        cmd_complete, cmd_timeout, blk_done, dat_error;
    logic [3:0]  irq_clr;
    logic        new_cmd, start_transfer, cmd_inhibit, dat_inhibit, q_full;
    logic [5:0]  cmd_index_out;
    logic [31:0] cmd_arg_out;
    logic [15:0] blk_remaining;
    logic [3:0]  irq_status;

    int n_tests = 0;
    int n_fail  = 0;
    int st_count = 0;
    bit done = 1'b0;

    sd_xfer_sequencer #(
        .CMD_Q_DEPTH (2),
        .BLK_CNT_W   (16),
        .TO_W        (20),
        .TO_LIMIT    (20'd16)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .cmd_wr          (cmd_wr),
        .cmd_index_in    (cmd_index_in),
        .cmd_arg_in      (cmd_arg_in),
        .data_present_in (data_present_in),
        .blk_cnt_in      (blk_cnt_in),
        .multi_blk_in    (multi_blk_in),
        .cmd_complete    (cmd_complete),
        .cmd_timeout     (cmd_timeout),
        .blk_done        (blk_done),
        .dat_error       (dat_error),
        .irq_clr         (irq_clr),
        .new_cmd         (new_cmd),
        .cmd_index_out   (cmd_index_out),
        .cmd_arg_out     (cmd_arg_out),
        .start_transfer  (start_transfer),
        .cmd_inhibit     (cmd_inhibit),
        .dat_inhibit     (dat_inhibit),
        .q_full          (q_full),
        .blk_remaining   (blk_remaining),
        .irq_status      (irq_status)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (start_transfer === 1'b1) st_count++;
    end

    initial begin
        #100000;
        if (!done) begin
            n_fail++;
            $error("FAIL watchdog: sequence did not finish in time");
            $finish;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        n_tests++;
        if ({new_cmd, start_transfer, cmd_inhibit, dat_inhibit, q_full} !== 5'b0 ||
            cmd_index_out !== 6'd0 || cmd_arg_out !== 32'd0 ||
            blk_remaining !== 16'd0 || irq_status !== 4'd0) begin
            n_fail++;
            $error("FAIL %s outputs not in reset state", tag);
        end
    endtask

    task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input logic dp, input logic [15:0] blk, input logic multi);
        cmd_index_in    = idx;
        cmd_arg_in      = arg;
        data_present_in = dp;
        blk_cnt_in      = blk;
        multi_blk_in    = multi;
        cmd_wr          = 1'b1;
        step();
        cmd_wr          = 1'b0;
    endtask

    task automatic respond();
        cmd_complete = 1'b1;
        step();
        cmd_complete = 1'b0;
    endtask

    task automatic clear_irq();
        irq_clr = 4'hF;
        step();
        irq_clr = 4'h0;
    endtask

    initial begin
        RESET = 1'b1;
        cmd_wr = 1'b0; cmd_index_in = '0; cmd_arg_in = '0; data_present_in = 1'b0;
        blk_cnt_in = '0; multi_blk_in = 1'b0; cmd_complete = 1'b0; cmd_timeout = 1'b0;
        blk_done = 1'b0; dat_error = 1'b0; irq_clr = '0;
        step();
        step();
        check_reset_state("rst_all");
        `CHECK("rst_new_cmd", new_cmd, 1'b0)
        `CHECK("rst_cmd_inhibit", cmd_inhibit, 1'b0)
        `CHECK("rst_dat_inhibit", dat_inhibit, 1'b0)
        `CHECK("rst_q_full", q_full, 1'b0)
        `CHECK("rst_irq", irq_status, 4'b0000)
        `CHECK("rst_blk_rem", blk_remaining, 16'd0)
        `CHECK("rst_start", start_transfer, 1'b0)
        RESET = 1'b0;
        step();

        // no-data command
        push_cmd(6'd8, 32'h1AA, 1'b0, 16'd0, 1'b0);
        `CHECK("t1_new_cmd_t1", new_cmd, 1'b0)
        step();
        `CHECK("t1_new_cmd_t2", new_cmd, 1'b1)
        `CHECK("t1_index", cmd_index_out, 6'd8)
        `CHECK("t1_arg", cmd_arg_out, 32'h1AA)
        `CHECK("t1_inhibit_issue", cmd_inhibit, 1'b1)
        step();
        `CHECK("t1_new_cmd_once", new_cmd, 1'b0)
        `CHECK("t1_inhibit_wait", cmd_inhibit, 1'b1)
        respond();
        `CHECK("t1_irq", irq_status, 4'b0001)
        `CHECK("t1_inhibit_clr", cmd_inhibit, 1'b0)
        `CHECK("t1_dat_inhibit", dat_inhibit, 1'b0)
        step();
        `CHECK("t1_no_start", st_count, 0)
        `CHECK("t1_index_hold", cmd_index_out, 6'd8)
        irq_clr = 4'b0001;
        step();
        irq_clr = 4'b0000;
        `CHECK("t1_irq_clr", irq_status, 4'b0000)

        // multi-block read of 3 blocks
        push_cmd(6'd18, 32'h100, 1'b1, 16'd3, 1'b1);
        step();
        `CHECK("t2_new_cmd", new_cmd, 1'b1)
        `CHECK("t2_index", cmd_index_out, 6'd18)
        step();
        respond();
        `CHECK("t2_start", start_transfer, 1'b1)
        `CHECK("t2_blk_load", blk_remaining, 16'd3)
        `CHECK("t2_dat_inhibit", dat_inhibit, 1'b1)
        `CHECK("t2_cmd_inhibit", cmd_inhibit, 1'b0)
        for (int i = 2; i >= 0; i--) begin
            blk_done = 1'b1;
            step();
            blk_done = 1'b0;
            `CHECK("t2_blk_rem", blk_remaining, 16'(i))
            `CHECK("t2_dat_inh_loop", dat_inhibit, (i != 0))
            `CHECK("t2_start_low", start_transfer, 1'b0)
        end
        `CHECK("t2_irq", irq_status, 4'b0011)
        `CHECK("t2_start_count", st_count, 1)
        blk_done = 1'b1;
        step();
        blk_done = 1'b0;
        `CHECK("t2_no_underflow", blk_remaining, 16'd0)
        clear_irq();

        // queue overflow while the first command waits for its response
        push_cmd(6'd17, 32'hA, 1'b0, 16'd0, 1'b0);
        step();
        step();
        cmd_wr = 1'b1;
        cmd_index_in = 6'd2; cmd_arg_in = 32'h2;
        step();
        `CHECK("t3_not_full", q_full, 1'b0)
        cmd_index_in = 6'd3; cmd_arg_in = 32'h3;
        step();
        `CHECK("t3_full", q_full, 1'b1)
        cmd_index_in = 6'd4; cmd_arg_in = 32'h4;
        step();
        cmd_wr = 1'b0;
        `CHECK("t3_ovf_irq", irq_status, 4'b0100)
        `CHECK("t3_still_full", q_full, 1'b1)
        respond();
        `CHECK("t3_irq_b", irq_status, 4'b0101)
        step();
        `CHECK("t3_b_issue", new_cmd, 1'b1)
        `CHECK("t3_b_index", cmd_index_out, 6'd2)
        `CHECK("t3_after_pop", q_full, 1'b0)
        step();
        respond();
        step();
        `CHECK("t3_c_issue", new_cmd, 1'b1)
        `CHECK("t3_c_index", cmd_index_out, 6'd3)
        `CHECK("t3_c_arg", cmd_arg_out, 32'h3)
        step();
        respond();
        step();
        `CHECK("t3_d_dropped", new_cmd, 1'b0)
        `CHECK("t3_idle_inhibit", cmd_inhibit, 1'b0)
        clear_irq();

        // complete and timeout in the same cycle: timeout wins
        push_cmd(6'd25, 32'h55, 1'b1, 16'd2, 1'b1);
        step();
        step();
        cmd_complete = 1'b1;
        cmd_timeout  = 1'b1;
        step();
        cmd_complete = 1'b0;
        cmd_timeout  = 1'b0;
        `CHECK("t5_irq", irq_status, 4'b0100)
        `CHECK("t5_dat_inhibit", dat_inhibit, 1'b0)
        `CHECK("t5_cmd_inhibit", cmd_inhibit, 1'b0)
        step();
        `CHECK("t5_no_start", st_count, 1)
        clear_irq();

        // data timeout, single block because multi is 0
        push_cmd(6'd17, 32'h0, 1'b1, 16'd5, 1'b0);
        step();
        step();
        respond();
        `CHECK("t4_blk_single", blk_remaining, 16'd1)
        `CHECK("t4_start", start_transfer, 1'b1)
        repeat (16) step();
        `CHECK("t4_before_to", irq_status, 4'b0001)
        `CHECK("t4_still_data", dat_inhibit, 1'b1)
        step();
        `CHECK("t4_to_irq", irq_status, 4'b1001)
        `CHECK("t4_dat_inh_clr", dat_inhibit, 1'b0)
        `CHECK("t4_start_count", st_count, 2)
        clear_irq();

        // blk_done with dat_error: error wins but the block still counts
        push_cmd(6'd18, 32'h7, 1'b1, 16'd3, 1'b1);
        step();
        step();
        respond();
        blk_done  = 1'b1;
        dat_error = 1'b1;
        step();
        blk_done  = 1'b0;
        dat_error = 1'b0;
        `CHECK("te_blk_rem", blk_remaining, 16'd2)
        `CHECK("te_irq", irq_status, 4'b1001)
        `CHECK("te_dat_inhibit", dat_inhibit, 1'b0)
        clear_irq();

        // asynchronous reset mid-transfer with a command still queued
        push_cmd(6'd40, 32'hBEEF, 1'b1, 16'd4, 1'b1);
        step();
        step();
        respond();
        blk_done = 1'b1;
        step();
        blk_done = 1'b0;
        `CHECK("t6_blk_rem", blk_remaining, 16'd3)
        push_cmd(6'd9, 32'h9, 1'b0, 16'd0, 1'b0);
        #1;
        RESET = 1'b1;
        #1;
        check_reset_state("t6_async_rst");
        `CHECK("t6_new_cmd", new_cmd, 1'b0)
        `CHECK("t6_index", cmd_index_out, 6'd0)
        `CHECK("t6_arg", cmd_arg_out, 32'h0)
        `CHECK("t6_cmd_inhibit", cmd_inhibit, 1'b0)
        `CHECK("t6_dat_inhibit", dat_inhibit, 1'b0)
        `CHECK("t6_blk_rem_rst", blk_remaining, 16'd0)
        `CHECK("t6_irq", irq_status, 4'b0000)
        step();
        RESET = 1'b0;
        step();
        step();
        `CHECK("t6_queue_empty", new_cmd, 1'b0)
        push_cmd(6'd5, 32'h77, 1'b0, 16'd0, 1'b0);
        `CHECK("t6_post_t1", new_cmd, 1'b0)
        step();
        `CHECK("t6_post_new_cmd", new_cmd, 1'b1)
        `CHECK("t6_post_index", cmd_index_out, 6'd5)
        `CHECK("t6_post_arg", cmd_arg_out, 32'h77)

        done = 1'b1;
        if (n_fail != 0)
            $error("FAIL summary: %0d of %0d checks failed", n_fail, n_tests);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
